// File: rtl/lx150t_trng_top.sv
// lx150t_trng_top: board-level TRNG top for the LX150T board.
//
// An 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) is seeded from the DIP switches
// while RESET is low and steps every clock. Every SAMPLE_DIV clocks the source
// is sampled onto the LEDs. The parity of each sample is one raw bit. Raw bits
// are packed LSB-first into bytes, and each byte goes out of the UART as an
// 8N1 frame. A byte that completes while the UART is busy is dropped, and a
// sticky internal overrun flag is set.
//
// Optional feature: define TRNG_VON_NEUMANN_EN to pass the raw bits through a
// von Neumann debiaser before the collector. The pair 01 emits 0, the pair 10
// emits 1, and the pairs 00 and 11 emit nothing.
//
// Parameters:
//   SAMPLE_DIV  clocks between source samples (1..255)
//   BAUD_DIV    clocks per UART bit (2..65535)
// Ports:
//   CLK                       in   system clock, rising edge
//   RESET                     in   asynchronous, active-low reset
//   DIP_Switches_8Bits_TRI_I  in   [7:0] LFSR seed; 0x00 loads 0x01
//   RS232_USB_sin             in   UART receive line, ignored
//   RS232_USB_sout            out  UART transmit line, idle high
//   LEDs_8Bits_TRI_O          out  [7:0] most recently sampled source byte
module lx150t_trng_top #(
  parameter int unsigned SAMPLE_DIV = 1,
  parameter int unsigned BAUD_DIV   = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] DIP_Switches_8Bits_TRI_I,
  input  logic       RS232_USB_sin,
  output logic       RS232_USB_sout,
  output logic [7:0] LEDs_8Bits_TRI_O
);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} tx_state_e;

  // Source and sampler
  logic [7:0] r_src;
  logic [7:0] r_led;
  logic [7:0] r_samp_cnt;
  logic       r_samp_stb;
  logic       w_fb;
  logic       w_samp_wrap;
  logic       w_raw;

  assign w_fb        = r_src[7] ^ r_src[5] ^ r_src[4] ^ r_src[3];
  assign w_samp_wrap = (r_samp_cnt == 8'(SAMPLE_DIV - 1));
  // r_led holds the byte sampled on the previous edge, which is the byte the strobe refers to
  assign w_raw       = ^r_led;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_src      <= (DIP_Switches_8Bits_TRI_I == 8'h00) ? 8'h01 : DIP_Switches_8Bits_TRI_I;
      r_led      <= 8'h00;
      r_samp_cnt <= 8'h00;
      r_samp_stb <= 1'b0;
    end else begin
      r_src      <= {r_src[6:0], w_fb};
      r_samp_stb <= w_samp_wrap;
      if (w_samp_wrap) begin
        r_samp_cnt <= 8'h00;
        r_led      <= r_src;
      end else begin
        r_samp_cnt <= r_samp_cnt + 8'd1;
      end
    end
  end

  // Bit conditioning
  logic w_bit_stb;
  logic w_bit;

`ifdef TRNG_VON_NEUMANN_EN
  logic r_vn_have;
  logic r_vn_first;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_vn_have  <= 1'b0;
      r_vn_first <= 1'b0;
    end else if (r_samp_stb) begin
      if (!r_vn_have) begin
        r_vn_first <= w_raw;
        r_vn_have  <= 1'b1;
      end else begin
        r_vn_have  <= 1'b0;
      end
    end
  end

  // The emitted value of a 01/10 pair is its first bit
  assign w_bit_stb = r_samp_stb & r_vn_have & (r_vn_first ^ w_raw);
  assign w_bit     = r_vn_first;
`else
  assign w_bit_stb = r_samp_stb;
  assign w_bit     = w_raw;
`endif

  // Collector
  logic [7:0] r_col;
  logic [2:0] r_bit_cnt;
  logic [7:0] w_byte;
  logic       w_byte_vld;

  assign w_byte     = {w_bit, r_col[7:1]};
  assign w_byte_vld = w_bit_stb & (r_bit_cnt == 3'd7);

  // All 8 bits are shifted in again before the next byte is taken, so the collector needs no clear
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_col     <= 8'h00;
      r_bit_cnt <= 3'd0;
    end else if (w_bit_stb) begin
      r_col     <= w_byte;
      r_bit_cnt <= r_bit_cnt + 3'd1;
    end
  end

  // UART transmitter
  tx_state_e  r_state, w_state_d;
  logic [15:0] r_baud_cnt, w_baud_cnt_d;
  logic [2:0]  r_bit_idx, w_bit_idx_d;
  logic [7:0]  r_tx_data, w_tx_data_d;
  logic        r_overrun, w_overrun_d;
  logic        w_baud_end;
  logic        w_sout;

  assign w_baud_end = (r_baud_cnt == 16'(BAUD_DIV - 1));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state    <= StIdle;
      r_baud_cnt <= 16'h0000;
      r_bit_idx  <= 3'd0;
      r_tx_data  <= 8'h00;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_baud_cnt <= w_baud_cnt_d;
      r_bit_idx  <= w_bit_idx_d;
      r_tx_data  <= w_tx_data_d;
      r_overrun  <= w_overrun_d;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_baud_cnt_d = w_baud_end ? 16'h0000 : r_baud_cnt + 16'd1;
    w_bit_idx_d  = r_bit_idx;
    w_tx_data_d  = r_tx_data;
    w_overrun_d  = r_overrun;
    case (r_state)
      StIdle: begin
        w_baud_cnt_d = 16'h0000;
        if (w_byte_vld) begin
          w_tx_data_d = w_byte;
          w_state_d   = StStart;
        end
      end
      StStart: begin
        if (w_baud_end) begin
          w_state_d   = StData;
          w_bit_idx_d = 3'd0;
        end
      end
      StData: begin
        if (w_baud_end) begin
          if (r_bit_idx == 3'd7) begin
            w_state_d = StStop;
          end else begin
            w_bit_idx_d = r_bit_idx + 3'd1;
          end
        end
      end
      StStop: begin
        if (w_baud_end) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
    // No buffering: a byte that arrives while a frame is in flight is lost
    if (w_byte_vld && (r_state != StIdle)) begin
      w_overrun_d = 1'b1;
    end
  end

  // Decoded from reset-cleared state, so a reset forces the line idle at once
  always_comb begin
    w_sout = 1'b1;
    case (r_state)
      StStart: w_sout = 1'b0;
      StData:  w_sout = r_tx_data[r_bit_idx];
      default: w_sout = 1'b1;
    endcase
  end

  assign RS232_USB_sout   = w_sout;
  assign LEDs_8Bits_TRI_O = r_led;

  // The receive line and the overrun flag have no external consumer
  logic w_unused;
  assign w_unused = ^{RS232_USB_sin, r_overrun};

endmodule

// File: tb/tb_lx150t_trng_top.sv
// Bench for lx150t_trng_top. Two instances share clock, reset and DIP:
// u_dut uses BAUD_DIV=16, and u_dut_ovr uses BAUD_DIV=200 so that it overruns.
// The expected byte stream (with completion cycle) is pushed to a queue per
// instance when the reset is released. A frame monitor pops and compares it
// against the serial frames seen on sout.
module tb_lx150t_trng_top;

  localparam int SDIV  = 1;
  localparam int NSAMP = 6000;

  typedef struct {
    int         edge_n;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] dip = 8'h00;
  logic       sin = 1'b1;
  logic       sout0, sout1;
  logic [7:0] led0, led1;
  int         cyc;
  int         n_tests = 0;
  int         n_fail = 0;
  exp_t       q0[$];
  exp_t       q1[$];

  always #5 clk = ~clk;

  // cyc == n at the negedge that follows the n-th rising edge after reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  lx150t_trng_top #(.SAMPLE_DIV(SDIV), .BAUD_DIV(16)) u_dut (
    .CLK                      (clk),
    .RESET                    (rst_n),
    .DIP_Switches_8Bits_TRI_I (dip),
    .RS232_USB_sin            (sin),
    .RS232_USB_sout           (sout0),
    .LEDs_8Bits_TRI_O         (led0)
  );

  lx150t_trng_top #(.SAMPLE_DIV(SDIV), .BAUD_DIV(200)) u_dut_ovr (
    .CLK                      (clk),
    .RESET                    (rst_n),
    .DIP_Switches_8Bits_TRI_I (dip),
    .RS232_USB_sin            (sin),
    .RS232_USB_sout           (sout1),
    .LEDs_8Bits_TRI_O         (led1)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  function automatic logic get_sout(input int id);
    return (id == 0) ? sout0 : sout1;
  endfunction

  // Reference model of sampler, parity, optional debiaser and collector
  task automatic gen_expect(input logic [7:0] seed);
    logic [7:0] s, col;
    logic       raw, first, have, b, emit;
    int         cnt, arr;
    exp_t       item;
    s = (seed == 8'h00) ? 8'h01 : seed;
    for (int k = 1; k < SDIV; k++) s = lfsr_step(s);
    col = 8'h00; cnt = 0; have = 1'b0; first = 1'b0;
    q0.delete();
    q1.delete();
    for (int n = 1; n <= NSAMP; n++) begin
      raw  = ^s;
      arr  = n * SDIV + 1;
      emit = 1'b0;
      b    = raw;
`ifdef TRNG_VON_NEUMANN_EN
      if (!have) begin
        first = raw;
        have  = 1'b1;
      end else begin
        have = 1'b0;
        if (first != raw) begin
          emit = 1'b1;
          b    = first;
        end
      end
`else
      emit = 1'b1;
`endif
      if (emit) begin
        col = {b, col[7:1]};
        cnt++;
        if (cnt == 8) begin
          item.edge_n = arr;
          item.data   = col;
          q0.push_back(item);
          q1.push_back(item);
          cnt = 0;
        end
      end
      for (int k = 0; k < SDIV; k++) s = lfsr_step(s);
    end
  endtask

  // Drop bytes that completed before the frame started; the next one must start it
  task automatic take_expected(input int id, input int e, output logic [7:0] d, output int ndrop);
    exp_t item;
    int   sz;
    ndrop = 0;
    d     = 8'h00;
    if (id == 0) begin
      while (q0.size() > 0 && q0[0].edge_n < e) begin void'(q0.pop_front()); ndrop++; end
      sz = q0.size();
    end else begin
      while (q1.size() > 0 && q1[0].edge_n < e) begin void'(q1.pop_front()); ndrop++; end
      sz = q1.size();
    end
    check_eq($sformatf("m%0d_sb_nonempty", id), sz > 0, 1);
    if (sz > 0) begin
      item = (id == 0) ? q0.pop_front() : q1.pop_front();
      check_eq($sformatf("m%0d_start_edge", id), e, item.edge_n);
      d = item.data;
    end
  endtask

  task automatic wait_start(input int id, input int limit, output int e, output bit ok);
    int n;
    n = 0;
    while (get_sout(id) !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    ok = (get_sout(id) === 1'b0);
    check_eq($sformatf("m%0d_start_seen", id), ok, 1);
    e = cyc;
  endtask

  task automatic mon_frames(input int id, input int baud, input int nframes);
    int         e, tgt, nd, total_drop;
    bit         ok;
    logic [7:0] d;
    logic       expb;
    total_drop = 0;
    for (int f = 0; f < nframes; f++) begin
      wait_start(id, 30 * baud + 100, e, ok);
      if (!ok) return;
      take_expected(id, e, d, nd);
      if (f == 0) check_eq($sformatf("m%0d_first_nodrop", id), nd, 0);
      else        total_drop += nd;
      for (int i = 0; i < 10; i++) begin
        expb = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : d[i-1];
        // First and last cycle of every bit cell
        for (int k = 0; k < 2; k++) begin
          tgt = e + baud * i + ((k == 0) ? 0 : baud - 1);
          while (cyc < tgt) @(negedge clk);
          check_eq($sformatf("m%0d_f%0d_bit%0d_c%0d", id, f, i, k), get_sout(id), expb);
        end
      end
    end
    if (id == 1) check_eq("ovr_bytes_dropped", total_drop > 0, 1);
  endtask

  task automatic check_leds(input logic [7:0] seed, input int n, input string tag);
    logic [7:0] s;
    s = (seed == 8'h00) ? 8'h01 : seed;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq($sformatf("%s_%0d", tag, i), led0, s);
      if (i < 4) check_eq($sformatf("%s_ovr_%0d", tag, i), led1, s);
      s = lfsr_step(s);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int         e, tgt, nd, j;
    bit         ok;
    logic [7:0] d;

    // Reset: outputs held at their reset values throughout
    dip = 8'hAA;
    #1 rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("rst_led", led0, 8'h00);
      check_eq("rst_led_ovr", led1, 8'h00);
      check_eq("rst_sout", sout0, 1'b1);
      check_eq("rst_sout_ovr", sout1, 1'b1);
    end

    gen_expect(8'hAA);
    release_reset();
    sin = 1'b0;
    fork
      check_leds(8'hAA, 40, "led_aa");
      mon_frames(0, 16, 4);
      mon_frames(1, 200, 2);
    join

    // Reset in the middle of a data bit that is driving 0
    wait_start(0, 500, e, ok);
    if (ok) begin
      take_expected(0, e, d, nd);
      j = 0;
      for (int k = 7; k >= 0; k--) if (!d[k]) j = k;
      tgt = e + 16 * (1 + j) + 8;
      while (cyc < tgt) @(negedge clk);
      check_eq("pre_rst_data_bit", sout0, d[j]);
      #1 rst_n = 1'b0;
      #1;
      check_eq("midframe_rst_sout", sout0, 1'b1);
      check_eq("midframe_rst_led", led0, 8'h00);
      check_eq("midframe_rst_sout_ovr", sout1, 1'b1);
    end else begin
      #1 rst_n = 1'b0;
    end
    repeat (3) @(negedge clk);
    release_reset();
    check_leds(8'hAA, 4, "led_restart");

    // Zero seed is replaced by 0x01
    @(negedge clk);
    #1 rst_n = 1'b0;
    dip = 8'h00;
    repeat (2) @(negedge clk);
    check_eq("zero_rst_led", led0, 8'h00);
    release_reset();
    check_leds(8'h00, 4, "led_zero");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
